lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit sitting between the RISC-V CPU core and `data_mem`: it initiates every data-memory access on the core's behalf. It accepts one byte/halfword/word load or store per handshake and checks alignment. It performs read-modify-write for sub-word stores, since `data_mem` only writes whole words, and sign/zero-extends load data back to the core. Its memory-side ports match `data_mem`: combinational word read, synchronous word write on the rising clock edge.

## Interface
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, word width. Only 32 is supported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: unit can accept a request. High only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: store data, right-aligned.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: core accepts the response.
- `resp_rdata` out DATA_WIDTH: extended load data. 0 for stores and errors.
- `resp_err` out 1: misaligned access or illegal funct3.
- `mem_addr` out ADDR_WIDTH: word-aligned address, {req_addr[31:2], 2'b00}.
- `mem_wdata` out DATA_WIDTH: full word to write.
- `mem_we` out 1: write enable. `data_mem` writes on the next rising edge.
- `mem_rdata` in DATA_WIDTH: combinational read data for `mem_addr`.

## Operation
- Request fields are captured into registers on the `req_valid && req_ready` edge. The core may change its inputs after that edge.
- States:
  - IDLE → ERR: on accept when the access is illegal. Illegal means: H/HU with addr[0] ≠ 0; W with addr[1:0] ≠ 0; funct3 outside {000, 001, 010, 100, 101}; store with funct3 = 100 or 101.
  - IDLE → WRITE: on accept of a legal SW. No read is needed.
  - IDLE → READ: on accept of any other legal access.
  - READ: drives `mem_addr`. Latches `mem_rdata` into `word_q`. Next state is RESP for a load, WRITE for a store.
  - WRITE: `mem_we` = 1 for exactly this one cycle. `mem_wdata` value:
    - SW: the captured wdata.
    - SB: `word_q` with lane addr[1:0] replaced by wdata[7:0].
    - SH: `word_q` with lane addr[1] replaced by wdata[15:0].
    - Other lanes are preserved bit-exactly; there is no OR-merge. Next state is RESP.
  - RESP / ERR: `resp_valid` = 1. Holds until `resp_ready`, then returns to IDLE. ERR additionally drives `resp_err` = 1 and `resp_rdata` = 0.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - B/H sign-extend to 32 bits; BU/HU zero-extend.
  - `resp_rdata` is registered from `word_q` and stays stable for the whole of RESP.
- Outside READ/WRITE, `mem_addr` holds the last captured address. `mem_wdata` is don't-care while `mem_we` = 0.
- ERR never asserts `mem_we` and never drives a new `mem_addr`.
- Addresses wrap naturally modulo 2^ADDR_WIDTH. `data_mem` applies its own modulo-64 word indexing.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, so `req_ready` = 1.
  - `resp_valid`, `resp_err`, `mem_we` = 0.
  - `resp_rdata`, `mem_addr`, `mem_wdata` = 0.
- Latency, counted from the accept edge to `resp_valid` high:
  - Load: 2 cycles (READ, then RESP).
  - SW: 2 cycles (WRITE, then RESP).
  - SB/SH: 3 cycles (READ, WRITE, RESP).
  - Error: 1 cycle.
- One outstanding request at a time. `req_ready` = 0 from the accept edge until the edge that completes the response handshake.
  - Back-to-back: the next accept can happen 1 cycle after the response handshake (IDLE lasts at least 1 cycle).
- `resp_valid` with `resp_ready` low: all `resp_*` outputs hold and the state stays put.
- Reset asserted mid-operation:
  - If in WRITE, `mem_we` drops immediately and no write occurs on the following edge.
  - The pending response is discarded.
- Any `req_valid` presented while `req_ready` = 0 is ignored. It is not queued.

## Structure
- Package `lsu_pkg` holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE, READ, WRITE, RESP, ERR), encoded in 3 bits.
- Sub-module `lsu_lane`, purely combinational, provides:
  - store lane merge: (word, wdata, funct3, addr[1:0]) → merged word;
  - load extract/extend: (word, funct3, addr[1:0]) → rdata.
- `lsu_ctrl` holds the FSM, the capture registers and `word_q`.

## Test plan
- SW addr 0x08, data 0xDEADBEEF → `mem_we` high exactly 1 cycle, `mem_addr` = 0x08, `mem_wdata` = 0xDEADBEEF. `resp_valid` 2 cycles after accept, `resp_err` = 0.
- Memory word 0x11223344 at 0x08:
  - SB addr 0x09, data 0x000000AA → written word 0x1122AA44.
  - Then SH addr 0x0A, data 0x0000BEEF → 0xBEEFAA44.
- Memory word 0x80FF0000 at 0x0C:
  - LB 0x0F → 0xFFFFFF80.
  - LBU 0x0F → 0x00000080.
  - LH 0x0E → 0xFFFF80FF.
  - LHU 0x0E → 0x000080FF.
  - LW 0x0C → 0x80FF0000.
- Error cases: LW 0x06, SH 0x03, and funct3 = 011 → each gives `resp_err` = 1 and `resp_rdata` = 0 one cycle after accept, with `mem_we` never asserted.
- `resp_ready` held low 3 cycles after an LB → `resp_valid` and `resp_rdata` stable throughout, `req_ready` = 0, a new `req_valid` is ignored. After the handshake, `req_ready` = 1 next cycle.
- `rst_n` pulsed low during the WRITE state of an SB → `mem_we` drops immediately and memory is unchanged. After release, state = IDLE, `req_ready` = 1, `resp_valid` = 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I width codes, FSM states, captured request.
// The legality check lives here so the controller and any future users agree on it.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    RESP  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Only the byte offset is kept; the word address lives in the mem_addr register.
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  addr_lo;
    logic [31:0] wdata;
  } req_t;

  function automatic logic access_illegal(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    return 1'b0;
      F3_H:    return addr_lo[0];
      F3_W:    return addr_lo != 2'b00;
      F3_BU:   return we;
      F3_HU:   return we | addr_lo[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response handshake plus the data_mem port of the load/store unit.
// slave = the LSU; master = whoever plays core and memory.
interface lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lsu_lane.sv
// Combinational byte/halfword lane logic: store merge into a whole word, load extract + extend.
// Zero latency; no handshake.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged,
  output logic [31:0] rdata
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = word[{addr_lo[1], 4'b0000} +: 16];

    // Untouched lanes come straight from the read word.
    merged = word;
    case (funct3)
      F3_B:    merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase

    case (funct3)
      F3_B:    rdata = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   rdata = {24'h0, byte_sel};
      F3_H:    rdata = {{16{half_sel[15]}}, half_sel};
      F3_HU:   rdata = {16'h0, half_sel};
      F3_W:    rdata = word;
      default: rdata = 32'h0;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM: one access at a time; 1 cycle for errors, 2 for loads/SW, 3 for SB/SH.
// req_ready only in IDLE; response held until resp_ready.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);
  state_t                state;
  req_t                  req_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] lane_word;
  logic [DATA_WIDTH-1:0] lane_merged;
  logic [DATA_WIDTH-1:0] lane_rdata;
  logic                  illegal;

  assign illegal = access_illegal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  // In READ the word is still on mem_rdata; it lands in word_q on the same edge.
  assign lane_word = (state == READ) ? bus.mem_rdata : word_q;

  lsu_lane u_lane (
    .word    (lane_word),
    .wdata   (req_q.wdata),
    .funct3  (req_q.funct3),
    .addr_lo (req_q.addr_lo),
    .merged  (lane_merged),
    .rdata   (lane_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_q          <= '0;
      word_q         <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            req_q         <= '{we: bus.req_we, funct3: bus.req_funct3,
                               addr_lo: bus.req_addr[1:0], wdata: bus.req_wdata};
            bus.req_ready <= 1'b0;
            if (illegal) begin
              state          <= ERR;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              bus.mem_addr <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (bus.req_we && bus.req_funct3 == F3_W) begin
                state         <= WRITE;
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= bus.req_wdata;
              end else begin
                state <= READ;
              end
            end
          end
        end
        READ: begin
          word_q <= bus.mem_rdata;
          if (req_q.we) begin
            state         <= WRITE;
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= lane_merged;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= lane_rdata;
          end
        end
        WRITE: begin
          state          <= RESP;
          bus.mem_we     <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        RESP, ERR: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.mem_we    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: plays core and a 64-word data_mem around the unit.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [31:0] mem [0:63];
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] r_rdata, r_waddr, r_wdata;
  logic        r_err;
  int          r_lat, r_wecnt;

  // Present one request, scramble the inputs after the accept edge, then wait for resp_valid.
  task automatic xact_start(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = ~addr;
    bus.req_wdata  = ~wdata;
    r_lat   = 1;
    r_wecnt = 0;
    r_waddr = 32'hx;
    r_wdata = 32'hx;
    while (!bus.resp_valid && r_lat < 10) begin
      if (bus.mem_we) begin
        r_wecnt++;
        r_waddr = bus.mem_addr;
        r_wdata = bus.mem_wdata;
      end
      @(posedge clk); #1;
      r_lat++;
    end
    if (bus.mem_we) r_wecnt++;
    chk("resp_valid_seen", 32'(bus.resp_valid), 32'd1);
    r_rdata = bus.resp_rdata;
    r_err   = bus.resp_err;
  endtask

  task automatic xact_finish();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("req_ready_after_hs", 32'(bus.req_ready), 32'd1);
    chk("resp_valid_after_hs", 32'(bus.resp_valid), 32'd0);
  endtask

  logic [2:0]  ld_f3   [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
  logic [31:0] ld_addr [5] = '{32'h0F, 32'h0F, 32'h0E, 32'h0E, 32'h0C};
  logic [31:0] ld_exp  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF0000};

  logic        er_we   [3] = '{1'b0, 1'b1, 1'b0};
  logic [2:0]  er_f3   [3] = '{F3_W, F3_H, 3'b011};
  logic [31:0] er_addr [3] = '{32'h06, 32'h03, 32'h00};

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SW: straight to WRITE
    xact_start(1'b1, F3_W, 32'h08, 32'hDEADBEEF);
    chk("sw_lat", r_lat, 2);
    chk("sw_we_cycles", r_wecnt, 1);
    chk("sw_mem_addr", r_waddr, 32'h08);
    chk("sw_mem_wdata", r_wdata, 32'hDEADBEEF);
    chk("sw_err", 32'(r_err), 32'd0);
    chk("sw_rdata", r_rdata, 32'h0);
    xact_finish();
    chk("sw_mem", mem[2], 32'hDEADBEEF);

    // Sub-word stores: read-modify-write preserving other lanes
    mem[2] = 32'h11223344;
    xact_start(1'b1, F3_B, 32'h09, 32'h000000AA);
    chk("sb_lat", r_lat, 3);
    chk("sb_we_cycles", r_wecnt, 1);
    chk("sb_mem_wdata", r_wdata, 32'h1122AA44);
    xact_finish();
    chk("sb_mem", mem[2], 32'h1122AA44);

    xact_start(1'b1, F3_H, 32'h0A, 32'h0000BEEF);
    chk("sh_lat", r_lat, 3);
    chk("sh_mem_wdata", r_wdata, 32'hBEEFAA44);
    xact_finish();
    chk("sh_mem", mem[2], 32'hBEEFAA44);

    // Loads with sign/zero extension
    mem[3] = 32'h80FF0000;
    for (int i = 0; i < 5; i++) begin
      xact_start(1'b0, ld_f3[i], ld_addr[i], 32'h0);
      chk($sformatf("ld%0d_rdata", i), r_rdata, ld_exp[i]);
      chk($sformatf("ld%0d_lat", i), r_lat, 2);
      chk($sformatf("ld%0d_err", i), 32'(r_err), 32'd0);
      chk($sformatf("ld%0d_we", i), r_wecnt, 0);
      xact_finish();
    end

    // Illegal accesses
    for (int i = 0; i < 3; i++) begin
      xact_start(er_we[i], er_f3[i], er_addr[i], 32'hFFFFFFFF);
      chk($sformatf("err%0d_err", i), 32'(r_err), 32'd1);
      chk($sformatf("err%0d_rdata", i), r_rdata, 32'h0);
      chk($sformatf("err%0d_lat", i), r_lat, 1);
      chk($sformatf("err%0d_we", i), r_wecnt, 0);
      xact_finish();
    end
    chk("err_mem_untouched", mem[0], 32'h0);

    // Response backpressure: outputs hold, new request ignored
    xact_start(1'b0, F3_B, 32'h0F, 32'h0);
    chk("hold_first_rdata", r_rdata, 32'hFFFFFF80);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h0C;
    bus.req_wdata  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d_resp_valid", i), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("hold%0d_rdata", i), bus.resp_rdata, 32'hFFFFFF80);
      chk($sformatf("hold%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
      chk($sformatf("hold%0d_mem_we", i), 32'(bus.mem_we), 32'd0);
    end
    bus.req_valid = 1'b0;
    xact_finish();
    chk("hold_mem_untouched", mem[3], 32'h80FF0000);

    // Reset during the WRITE of an SB
    mem[2] = 32'h11223344;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h09;
    bus.req_wdata  = 32'h000000AA;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstw_in_write", 32'(bus.mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_drop", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstw_mem", mem[2], 32'h11223344);
    chk("rstw_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rstw_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    xact_start(1'b0, F3_W, 32'h08, 32'h0);
    chk("post_rst_lw", r_rdata, 32'h11223344);
    xact_finish();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
